// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing, counter widths and pixel types shared by the
// VGA sync generator, its pixel interface and its bench.
package vga_timing_pkg;

    localparam int H_ACTIVE_D = 640;
    localparam int H_FP_D     = 16;
    localparam int H_SYNC_D   = 96;
    localparam int H_BP_D     = 48;
    localparam int H_TOTAL_D  = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;

    localparam int V_ACTIVE_D = 480;
    localparam int V_FP_D     = 10;
    localparam int V_SYNC_D   = 2;
    localparam int V_BP_D     = 33;
    localparam int V_TOTAL_D  = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

    // Counter widths; 800 and 525 both fit in 10 bits.
    localparam int H_W   = 10;
    localparam int V_W   = 10;
    localparam int RGB_W = 24;

    typedef logic [H_W-1:0] hcnt_t;
    typedef logic [V_W-1:0] vcnt_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_sync_gen_if.sv
// Pixel stream from the frame source into the sync generator.
// The source drives data/valid, the generator answers with ready.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic [RGB_W-1:0] pix_data;
    logic             pix_valid;
    logic             pix_ready;

    modport master (output pix_data, output pix_valid, input pix_ready);
    modport slave  (input pix_data, input pix_valid, output pix_ready);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_p0;

    // Capture the async level, then re-time it once more before use.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_p0 <= 1'b0;
            q       <= 1'b0;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: walks the raster with h/v counters, pulls one pixel
// per visible slot from the source and registers colour, syncs and blanking
// one cycle after each slot. Stops and parks at (0,0) while the PLL is unlocked.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              locked,
    vga_sync_gen_if.slave     pix,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_blank_n,
    output logic              vga_sync_n,
    output logic              frame_start,
    output logic              underflow,
    input  logic              underflow_clr
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam hcnt_t H_ACT_C     = H_W'(H_ACTIVE);
    localparam hcnt_t H_SYNC_FRST = H_W'(H_ACTIVE + H_FP);
    localparam hcnt_t H_SYNC_LAST = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam hcnt_t H_LAST      = H_W'(H_TOTAL - 1);

    localparam vcnt_t V_ACT_C     = V_W'(V_ACTIVE);
    localparam vcnt_t V_SYNC_FRST = V_W'(V_ACTIVE + V_FP);
    localparam vcnt_t V_SYNC_LAST = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam vcnt_t V_LAST      = V_W'(V_TOTAL - 1);

    logic  run;
    hcnt_t hcnt;
    vcnt_t vcnt;
    logic  active;
    logic  xfer;
    logic  starve;
    logic  hs_slot;
    logic  vs_slot;

    rgb_t  rgb_p1;
    logic  hs_p1;
    logic  vs_p1;
    logic  vld_p1;
    logic  fs_p1;
    logic  uf_p1;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (locked),
        .q   (run)
    );

    // Raster position; held at the origin whenever the clock is not trusted.
    always_ff @(posedge refclk) begin
        if (rst || !run) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + V_W'(1);
        end else begin
            hcnt <= hcnt + H_W'(1);
        end
    end

    // Slot decode from the registered counters; ready is gated by rst so a
    // reset cycle can never consume a pixel.
    always_comb begin
        active        = (hcnt < H_ACT_C) && (vcnt < V_ACT_C);
        pix.pix_ready = run && active && !rst;
        xfer          = pix.pix_ready && pix.pix_valid;
        starve        = pix.pix_ready && !pix.pix_valid;
        hs_slot       = !((hcnt >= H_SYNC_FRST) && (hcnt <= H_SYNC_LAST));
        vs_slot       = !((vcnt >= V_SYNC_FRST) && (vcnt <= V_SYNC_LAST));
    end

    // ---- stage p1: registered DAC/sync outputs, one cycle after the slot ----
    always_ff @(posedge refclk) begin
        if (rst || !run) begin
            rgb_p1 <= '0;
            hs_p1  <= 1'b1;
            vs_p1  <= 1'b1;
            vld_p1 <= 1'b0;
            fs_p1  <= 1'b0;
            uf_p1  <= 1'b0;
        end else begin
            rgb_p1 <= xfer ? rgb_t'(pix.pix_data) : '0;
            hs_p1  <= hs_slot;
            vs_p1  <= vs_slot;
            vld_p1 <= active;
            fs_p1  <= (hcnt == '0) && (vcnt == '0);
            // A new starvation wins over a clear in the same cycle.
            if (starve) begin
                uf_p1 <= 1'b1;
            end else if (underflow_clr) begin
                uf_p1 <= 1'b0;
            end
        end
    end

    assign vga_r       = rgb_p1.r;
    assign vga_g       = rgb_p1.g;
    assign vga_b       = rgb_p1.b;
    assign vga_hs      = hs_p1;
    assign vga_vs      = vs_p1;
    assign vga_blank_n = vld_p1;
    assign vga_sync_n  = 1'b0;
    assign frame_start = fs_p1;
    assign underflow   = uf_p1;

endmodule
